// File: rtl/gearbox_pkg.sv
// Shared helpers for the data gearbox: fill-counter sizing, parameter legality
// and the flush FSM state encoding.
package gearbox_pkg;

   typedef enum logic {
      ST_STREAM = 1'b0,
      ST_FLUSH  = 1'b1
   } flush_state_e;

   // Bits needed to count 0..n inclusive.
   function automatic int fill_width(input int n);
      return $clog2(n + 1);
   endfunction

   // The accumulator must hold one partial output word plus a full input word,
   // otherwise the source could stall forever below the output threshold.
   function automatic bit params_legal(input int in_w, input int out_w, input int buf_w);
      return (in_w >= 1) && (out_w >= 1) && (buf_w >= out_w + in_w);
   endfunction

endpackage

// File: rtl/data_gearbox_acc.sv
// Bit accumulator datapath: shifts out OUT_W bits on pop, ORs IN_W bits in
// just above the remaining residue on push. The oldest bit sits at bit 0 and
// everything above fill is kept zero, so a short final word reads zero-padded.
module gearbox_acc
   import gearbox_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 23,
   parameter int BUF_W  = 55,
   parameter int FILL_W = fill_width(BUF_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic [IN_W-1:0]   data_in,
   output logic [OUT_W-1:0]  data_out,
   output logic [FILL_W-1:0] fill
);

   localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
   localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_W);

   logic [BUF_W-1:0]  acc;
   logic [BUF_W-1:0]  acc_pop;
   logic [BUF_W-1:0]  acc_nxt;
   logic [FILL_W-1:0] fill_pop;
   logic [FILL_W-1:0] fill_nxt;

   // Pop first, then land the new word right after the shifted residue.
   always_comb begin
      acc_pop  = acc;
      fill_pop = fill;
      if (pop) begin
         acc_pop  = acc >> OUT_W;
         fill_pop = (fill > OUT_W_F) ? (fill - OUT_W_F) : '0;
      end
      acc_nxt  = acc_pop;
      fill_nxt = fill_pop;
      if (push) begin
         acc_nxt  = acc_pop | (BUF_W'(data_in) << fill_pop);
         fill_nxt = fill_pop + IN_W_F;
      end
   end

   // Accumulator and fill registers; reset and clear both discard all bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         fill <= '0;
      end else if (clear) begin
         acc  <= '0;
         fill <= '0;
      end else begin
         acc  <= acc_nxt;
         fill <= fill_nxt;
      end
   end

   assign data_out = acc[OUT_W-1:0];

endmodule

// File: rtl/data_gearbox.sv
// Width-conversion gearbox: packs IN_W-bit words into OUT_W-bit words,
// LSB-first, with valid/ready on both sides and a packet-end flush that
// zero-pads the final partial word and marks it with last_sink.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_STREAM | accepting input, emitting only full OUT_W beats
// ST_FLUSH  | last word taken; input blocked, draining to an empty buffer
module data_gearbox
   import gearbox_pkg::*;
#(
   parameter  int IN_W   = 16,
   parameter  int OUT_W  = 23,
   parameter  int BUF_W  = 55,
   localparam int FILL_W = fill_width(BUF_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_src,
   input  logic [IN_W-1:0]   data_in,
   input  logic              last_src,
   output logic              rdy_src,
   output logic [OUT_W-1:0]  data_out,
   output logic              valid_sink,
   output logic              last_sink,
   input  logic              rdy_sink,
   output logic [FILL_W-1:0] fill_level
);

   if (!params_legal(IN_W, OUT_W, BUF_W)) begin : g_param_check
      $error("data_gearbox: BUF_W=%0d is smaller than OUT_W+IN_W=%0d", BUF_W, OUT_W + IN_W);
   end

   localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
   localparam logic [FILL_W-1:0] RDY_MAX = FILL_W'(BUF_W - IN_W);

   flush_state_e      state;
   flush_state_e      state_nxt;
   logic              flush;
   logic              push;
   logic              pop;
   logic [FILL_W-1:0] fill;

   gearbox_acc #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .BUF_W  (BUF_W),
      .FILL_W (FILL_W)
   ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .clear    (1'b0),
      .push     (push),
      .pop      (pop),
      .data_in  (data_in),
      .data_out (data_out),
      .fill     (fill)
   );

   assign flush      = (state == ST_FLUSH);
   assign fill_level = fill;

   // Flush state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_STREAM;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshakes and flush transitions; rdy_src deliberately ignores rdy_sink.
   always_comb begin
      rdy_src    = !rst && !flush && (fill <= RDY_MAX);
      valid_sink = (fill >= OUT_W_F) || (flush && (fill != '0));
      last_sink  = flush && (fill <= OUT_W_F) && valid_sink;
      push       = valid_src && rdy_src;
      pop        = valid_sink && rdy_sink;
      state_nxt  = state;
      case (state)
         ST_STREAM: if (push && last_src)  state_nxt = ST_FLUSH;
         ST_FLUSH:  if (pop && last_sink)  state_nxt = ST_STREAM;
         default:                          state_nxt = ST_STREAM;
      endcase
   end

   // A source that is waiting must keep its word presented.
   a_src_hold: assert property (@(posedge clk) disable iff (rst)
      (valid_src && !rdy_src) |=> valid_src);

endmodule

// File: tb/tb_data_gearbox.sv
// Scoreboard bench for data_gearbox: a bit-level reference queue turns every
// accepted word into expected output beats, compared as the sink pops them.
module tb_data_gearbox;
   import gearbox_pkg::*;

   localparam int IN_W   = 16;
   localparam int OUT_W  = 23;
   localparam int BUF_W  = 55;
   localparam int FILL_W = fill_width(BUF_W);

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             last;
      int               nbits;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              valid_src = 1'b0;
   logic [IN_W-1:0]   data_in = '0;
   logic              last_src = 1'b0;
   logic              rdy_src;
   logic [OUT_W-1:0]  data_out;
   logic              valid_sink;
   logic              last_sink;
   logic              rdy_sink = 1'b0;
   logic [FILL_W-1:0] fill_level;

   int    n_checks = 0;
   int    n_errors = 0;
   int    sink_mode = 0;
   beat_t exp_q[$];
   beat_t got_q[$];
   bit    pend_q[$];
   bit    mflush = 1'b0;

   data_gearbox #(.IN_W(IN_W), .OUT_W(OUT_W), .BUF_W(BUF_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_src  (valid_src),
      .data_in    (data_in),
      .last_src   (last_src),
      .rdy_src    (rdy_src),
      .data_out   (data_out),
      .valid_sink (valid_sink),
      .last_sink  (last_sink),
      .rdy_sink   (rdy_sink),
      .fill_level (fill_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int model_fill();
      int f = pend_q.size();
      foreach (exp_q[i]) f += exp_q[i].nbits;
      return f;
   endfunction

   task automatic emit_beat(input logic lst_pkt);
      beat_t b;
      b.data  = '0;
      b.nbits = 0;
      for (int i = 0; i < OUT_W; i++) begin
         if (pend_q.size() > 0) begin
            b.data[i] = pend_q.pop_front();
            b.nbits++;
         end
      end
      b.last = lst_pkt && (pend_q.size() == 0);
      exp_q.push_back(b);
   endtask

   task automatic model_push(input logic [IN_W-1:0] d, input logic lst);
      for (int i = 0; i < IN_W; i++) pend_q.push_back(d[i]);
      if (lst) begin
         mflush = 1'b1;
         while (pend_q.size() > 0) emit_beat(1'b1);
      end else begin
         while (pend_q.size() >= OUT_W) emit_beat(1'b0);
      end
   endtask

   // Sink readiness: 0 always ready, 1 stalled, otherwise random.
   initial forever begin
      @(posedge clk);
      #2;
      case (sink_mode)
         0:       rdy_sink = 1'b1;
         1:       rdy_sink = 1'b0;
         default: rdy_sink = ($urandom_range(0, 2) != 0);
      endcase
   end

   // Observe the handshakes that the coming rising edge will perform.
   always @(negedge clk) begin
      beat_t e;
      beat_t g;
      int    mf;
      bit    do_push;
      bit    do_pop;
      if (rst) begin
         exp_q.delete();
         pend_q.delete();
         mflush = 1'b0;
      end else begin
         mf      = model_fill();
         do_push = valid_src && rdy_src;
         do_pop  = valid_sink && rdy_sink;
         check("fill_level", 64'(fill_level), 64'(mf));
         check("valid_sink", 64'(valid_sink), 64'(exp_q.size() != 0));
         check("rdy_src", 64'(rdy_src), 64'(!mflush && (mf <= BUF_W - IN_W)));
         if (do_pop) begin
            g.data  = data_out;
            g.last  = last_sink;
            g.nbits = 0;
            got_q.push_back(g);
            if (exp_q.size() == 0) begin
               check("beat_extra", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("beat_data", 64'(data_out), 64'(e.data));
               check("beat_last", 64'(last_sink), 64'(e.last));
               if (e.last) mflush = 1'b0;
            end
         end
         if (do_push) model_push(data_in, last_src);
      end
   end

   task automatic wait_accept();
      int n = 0;
      bit took = 1'b0;
      while (!took && n < 200) begin
         @(negedge clk);
         took = rdy_src;
         @(posedge clk);
         #1;
         n++;
      end
      if (!took) check("accept_timeout", 64'(0), 64'(1));
      valid_src = 1'b0;
      last_src  = 1'b0;
   endtask

   task automatic send_word(input logic [IN_W-1:0] d, input logic lst);
      valid_src = 1'b1;
      data_in   = d;
      last_src  = lst;
      wait_accept();
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || pend_q.size() != 0 || fill_level != '0) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 3000) check("drain_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      int            nl;
      logic [31:0]   pf_exp [3];
      logic [OUT_W-1:0] front;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy_src", 64'(rdy_src), 64'(0));
      check("rst_valid_sink", 64'(valid_sink), 64'(0));
      check("rst_last_sink", 64'(last_sink), 64'(0));
      check("rst_data_out", 64'(data_out), 64'(0));
      check("rst_fill", 64'(fill_level), 64'(0));
      rst = 1'b0;
      #1;
      check("rdy_after_rst", 64'(rdy_src), 64'(1));
      @(posedge clk);
      #1;

      // Aligned stream: 23 words -> 16 beats, last on the final full beat
      sink_mode = 0;
      got_q.delete();
      for (int k = 0; k < 23; k++) send_word(IN_W'(k + 1), k == 22);
      wait_drain();
      check("al_beats", 64'(got_q.size()), 64'(16));
      if (got_q.size() >= 16) begin
         check("al_beat0", 64'(got_q[0].data), 64'h020001);
         check("al_beat1", 64'(got_q[1].data), 64'h000600);
         check("al_last15", 64'(got_q[15].last), 64'(1));
      end
      nl = 0;
      foreach (got_q[i]) if (got_q[i].last) nl++;
      check("al_last_cnt", 64'(nl), 64'(1));
      check("al_fill_end", 64'(fill_level), 64'(0));

      // Padded flush
      got_q.delete();
      send_word(16'hFFFF, 1'b0);
      send_word(16'hFFFF, 1'b0);
      send_word(16'hFFFF, 1'b1);
      check("pf_rdy_after_last", 64'(rdy_src), 64'(0));
      @(posedge clk);
      #1;
      check("pf_rdy_hold", 64'(rdy_src), 64'(0));
      wait_drain();
      check("pf_rdy_release", 64'(rdy_src), 64'(1));
      check("pf_beats", 64'(got_q.size()), 64'(3));
      pf_exp[0] = 32'h7FFFFF;
      pf_exp[1] = 32'h7FFFFF;
      pf_exp[2] = 32'h000003;
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         check($sformatf("pf_beat%0d", i), 64'(got_q[i].data), 64'(pf_exp[i]));
         check($sformatf("pf_last%0d", i), 64'(got_q[i].last), 64'(i == 2));
      end

      // Backpressure: sink stalled, source keeps offering
      sink_mode = 1;
      for (int i = 0; i < 3; i++) send_word(IN_W'($urandom), 1'b0);
      valid_src = 1'b1;
      data_in   = IN_W'($urandom);
      last_src  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("bp_fill", 64'(fill_level), 64'(48));
      check("bp_rdy_src", 64'(rdy_src), 64'(0));
      check("bp_valid", 64'(valid_sink), 64'(1));
      front = (exp_q.size() != 0) ? exp_q[0].data : '0;
      check("bp_front", 64'(data_out), 64'(front));
      repeat (3) @(posedge clk);
      #1;
      check("bp_stable", 64'(data_out), 64'(front));
      check("bp_valid_hold", 64'(valid_sink), 64'(1));
      sink_mode = 0;
      @(posedge clk);
      #1;
      sink_mode = 1;
      check("bp_fill_release", 64'(fill_level), 64'(25));
      check("bp_rdy_release", 64'(rdy_src), 64'(1));
      wait_accept();
      sink_mode = 0;
      send_word(IN_W'($urandom), 1'b1);
      wait_drain();

      // Simultaneous push/pop, always-ready sink
      for (int i = 0; i < 100; i++) send_word(IN_W'($urandom), i == 99);
      wait_drain();

      // Random traffic and sink stalls with random packet boundaries
      sink_mode = 2;
      for (int i = 0; i < 200; i++) begin
         send_word(IN_W'($urandom), (i == 199) || ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      wait_drain();

      // Reset mid-packet with a flush pending
      sink_mode = 1;
      send_word(IN_W'($urandom), 1'b0);
      send_word(IN_W'($urandom), 1'b0);
      send_word(IN_W'($urandom), 1'b1);
      @(posedge clk);
      #1;
      check("rm_fill_pre", 64'(fill_level), 64'(48));
      rst = 1'b1;
      #1;
      check("rm_data_out", 64'(data_out), 64'(0));
      check("rm_valid", 64'(valid_sink), 64'(0));
      check("rm_last", 64'(last_sink), 64'(0));
      check("rm_rdy_src", 64'(rdy_src), 64'(0));
      check("rm_fill", 64'(fill_level), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      sink_mode = 0;
      got_q.delete();
      send_word(16'hABCD, 1'b0);
      send_word(16'h1234, 1'b1);
      wait_drain();
      check("rm_beats", 64'(got_q.size()), 64'(2));
      if (got_q.size() >= 2) begin
         check("rm_beat0", 64'(got_q[0].data), 64'h34ABCD);
         check("rm_beat1", 64'(got_q[1].data), 64'h000024);
         check("rm_last0", 64'(got_q[0].last), 64'(0));
         check("rm_last1", 64'(got_q[1].last), 64'(1));
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
